// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity types, default width.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int unsigned DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity bit for a data word, even or odd as selected by par_typ.
module parity_calc
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  parity
);

   always_comb begin
      parity = ^data;
      case (par_typ)
         PAR_EVEN: parity = ^data;
         PAR_ODD:  parity = ~^data;
         default:  parity = ^data;
      endcase
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, serializer data, optional parity, stop bit(s).
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned TIMEOUT    = DATA_WIDTH + 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  ser_data,
   input  logic                  ser_done,
   output logic [DATA_WIDTH-1:0] ser_p_data,
   output logic                  ser_en,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  data_ack,
   output logic                  err_timeout
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam int unsigned SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic [SW-1:0]           stop_cnt;
   logic [DATA_WIDTH-1:0]   data_reg;
   logic                    par_reg;
   logic                    par_en_reg;
   logic                    par_bit;
   logic                    stop_last;
   logic                    accept;
   logic                    timeout_hit;

   parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data    (p_data),
      .par_typ (par_typ),
      .parity  (par_bit)
   );

   assign stop_last   = (state == STOP) && (stop_cnt == SW'(STOP_BITS - 1));
   assign accept      = data_valid && ((state == IDLE) || stop_last);
   // ser_done takes priority over an expiring timeout in the same cycle
   assign timeout_hit = (state == DATA) && !ser_done && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         data_reg   <= '0;
         par_reg    <= 1'b0;
         par_en_reg <= 1'b0;
         cnt        <= '0;
         stop_cnt   <= '0;
      end else begin
         if (accept) begin
            data_reg   <= p_data;
            par_en_reg <= par_en;
            par_reg    <= par_bit;
         end
         stop_cnt <= (state == STOP) ? stop_cnt + SW'(1) : '0;
         case (state)
            IDLE: begin
               if (accept) state <= START;
            end
            START: begin
               state <= DATA;
               cnt   <= '0;
            end
            DATA: begin
               cnt <= cnt + CW'(1);
               if (ser_done)         state <= par_en_reg ? PARITY : STOP;
               else if (timeout_hit) state <= STOP;
            end
            PARITY: state <= STOP;
            STOP: begin
               if (stop_last) state <= accept ? START : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      tx_out = 1'b1;
      case (state)
         IDLE:    tx_out = 1'b1;
         START:   tx_out = 1'b0;
         DATA:    tx_out = ser_data;
         PARITY:  tx_out = par_reg;
         STOP:    tx_out = 1'b1;
         default: tx_out = 1'b1;
      endcase
   end

   assign busy        = (state != IDLE);
   assign ser_en      = (state == DATA);
   assign ser_p_data  = data_reg;
   assign data_ack    = accept;
   assign err_timeout = timeout_hit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural LSB-first serializer alongside it.
module tb_uart_tx_ctrl;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] p_data = '0;
   logic          data_valid = 1'b0;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic          ser_data;
   logic          ser_done;
   logic [DW-1:0] ser_p_data;
   logic          ser_en;
   logic          tx_out;
   logic          busy;
   logic          data_ack;
   logic          err_timeout;

   logic [2:0]    ser_idx;
   logic          block_done = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .p_data      (p_data),
      .data_valid  (data_valid),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .ser_data    (ser_data),
      .ser_done    (ser_done),
      .ser_p_data  (ser_p_data),
      .ser_en      (ser_en),
      .tx_out      (tx_out),
      .busy        (busy),
      .data_ack    (data_ack),
      .err_timeout (err_timeout)
   );

   // Serializer: shifts LSB first while enabled, flags the last bit
   always @(posedge clk) begin
      if (rst || !ser_en) ser_idx <= '0;
      else                ser_idx <= ser_idx + 3'd1;
   end
   assign ser_data = ser_p_data[ser_idx];
   assign ser_done = ser_en && (ser_idx == 3'd7) && !block_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accept one byte from IDLE, then walk the frame until busy drops (bounded)
   task automatic send_frame(input string tag, input logic [7:0] b, input logic pe,
                             input logic pt, input logic exp_par);
      logic tx_log [32];
      logic [7:0] bits;
      int busy_n;
      int ack_n;
      int err_n;
      @(negedge clk);
      p_data = b; par_en = pe; par_typ = pt; data_valid = 1'b1;
      #1;
      check_eq({tag, "_ack"}, 32'(data_ack), 32'd1);
      @(negedge clk);
      // inputs may change freely once acked
      data_valid = 1'b0; p_data = ~b; par_en = ~pe; par_typ = ~pt;
      #1;
      busy_n = 0; ack_n = 0; err_n = 0;
      while (busy && busy_n < 24) begin
         tx_log[busy_n] = tx_out;
         ack_n += int'(data_ack);
         err_n += int'(err_timeout);
         busy_n++;
         @(negedge clk);
         #1;
      end
      check_eq({tag, "_busy_len"}, 32'(busy_n), pe ? 32'd11 : 32'd10);
      check_eq({tag, "_no_ack"}, 32'(ack_n), 32'd0);
      check_eq({tag, "_no_err"}, 32'(err_n), 32'd0);
      check_eq({tag, "_start"}, 32'(tx_log[0]), 32'd0);
      for (int i = 0; i < 8; i++) bits[i] = tx_log[i + 1];
      check_eq({tag, "_data"}, 32'(bits), 32'(b));
      if (pe) check_eq({tag, "_parity"}, 32'(tx_log[9]), 32'(exp_par));
      if (busy_n >= 1) check_eq({tag, "_stop"}, 32'(tx_log[busy_n - 1]), 32'd1);
      check_eq({tag, "_idle_tx"}, 32'(tx_out), 32'd1);
   endtask

   initial begin
      logic b2b_tx   [24];
      logic b2b_busy [24];
      logic b2b_ack  [24];
      logic [7:0] bits;
      int ack_early;
      int busy_n;
      int err_at;
      int err_n;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_tx", 32'(tx_out), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ser_en", 32'(ser_en), 32'd0);
      check_eq("rst_ack", 32'(data_ack), 32'd0);
      check_eq("rst_err", 32'(err_timeout), 32'd0);
      check_eq("rst_ser_p_data", 32'(ser_p_data), 32'd0);
      rst = 1'b0;

      // 0xB9 popcount 5: even parity bit 1
      send_frame("even_b9", 8'hB9, 1'b1, 1'b0, 1'b1);
      // 0xB5 popcount 5: odd parity bit 0
      send_frame("odd_b5", 8'hB5, 1'b1, 1'b1, 1'b0);

      // 0x89 without parity, then 0x45 with odd parity (popcount 3 -> bit 0) held back-to-back
      @(negedge clk);
      p_data = 8'h89; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      #1;
      check_eq("b2b_ack1", 32'(data_ack), 32'd1);
      for (int k = 1; k < 24; k++) begin
         @(negedge clk);
         if (k == 1) data_valid = 1'b0;
         if (k == 3) begin
            p_data = 8'h45; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
         end
         if (k == 11) data_valid = 1'b0;
         #1;
         b2b_tx[k] = tx_out; b2b_busy[k] = busy; b2b_ack[k] = data_ack;
      end
      ack_early = 0;
      for (int k = 1; k < 10; k++) ack_early += int'(b2b_ack[k]);
      check_eq("b2b_no_early_ack", 32'(ack_early), 32'd0);
      check_eq("b2b_ack_in_stop", 32'(b2b_ack[10]), 32'd1);
      check_eq("b2b_stop1", 32'(b2b_tx[10]), 32'd1);
      check_eq("b2b_start2", 32'(b2b_tx[11]), 32'd0);
      for (int i = 0; i < 8; i++) bits[i] = b2b_tx[i + 2];
      check_eq("b2b_data1", 32'(bits), 32'h89);
      for (int i = 0; i < 8; i++) bits[i] = b2b_tx[i + 12];
      check_eq("b2b_data2", 32'(bits), 32'h45);
      check_eq("b2b_parity2", 32'(b2b_tx[20]), 32'd0);
      check_eq("b2b_stop2", 32'(b2b_tx[21]), 32'd1);
      busy_n = 0;
      for (int k = 1; k < 22; k++) busy_n += int'(b2b_busy[k]);
      check_eq("b2b_busy_len", 32'(busy_n), 32'd21);
      check_eq("b2b_idle", 32'(b2b_busy[22]), 32'd0);

      // Timeout: serializer never signals done
      block_done = 1'b1;
      @(negedge clk);
      p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
      #1;
      check_eq("to_ack", 32'(data_ack), 32'd1);
      @(negedge clk);
      data_valid = 1'b0;
      err_at = 0; err_n = 0;
      for (int d = 1; d <= 10; d++) begin
         @(negedge clk);
         #1;
         if (err_timeout) begin
            err_n++;
            if (err_at == 0) err_at = d;
         end
      end
      check_eq("to_err_cycle", 32'(err_at), 32'd10);
      check_eq("to_err_count", 32'(err_n), 32'd1);
      @(negedge clk);
      #1;
      check_eq("to_stop_tx", 32'(tx_out), 32'd1);
      check_eq("to_stop_busy", 32'(busy), 32'd1);
      check_eq("to_stop_ser_en", 32'(ser_en), 32'd0);
      check_eq("to_stop_err", 32'(err_timeout), 32'd0);
      @(negedge clk);
      #1;
      check_eq("to_idle", 32'(busy), 32'd0);
      block_done = 1'b0;

      // Reset at DATA cycle 4
      @(negedge clk);
      p_data = 8'h00; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
      #1;
      check_eq("mr_ack", 32'(data_ack), 32'd1);
      @(negedge clk);
      data_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check_eq("mr_in_data", 32'(ser_en), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_eq("mr_tx", 32'(tx_out), 32'd1);
      check_eq("mr_busy", 32'(busy), 32'd0);
      check_eq("mr_ser_en", 32'(ser_en), 32'd0);
      rst = 1'b0;
      send_frame("post_rst", 8'hB5, 1'b1, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
